// File: rtl/csa_accumulator_pkg.sv
// Shared types and elaboration-time helpers for the carry-save accumulator.
// csa_count/csa_levels size the Wallace-style reduction tree.
package csa_pkg;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} csa_state_e;

  localparam int OUT_BEATS_W = 16;

  // One 3:2 level turns every full group of three vectors into two.
  function automatic int csa_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int csa_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = csa_next(c);
    return c;
  endfunction

  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = csa_next(c);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/csa_accumulator_3to2.sv
// Vector 3:2 compressor: bitwise full adders, carry pre-shifted left by one.
// carry_drop is the majority bit that falls off the top of the carry vector.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry,
  output logic         carry_drop
);

  logic [W-1:0] maj;

  assign sum        = a ^ b ^ c;
  assign maj        = (a & b) | (a & c) | (b & c);
  assign carry      = {maj[W-2:0], 1'b0};
  assign carry_drop = maj[W-1];

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand carry-save accumulator with a single CPA per packet.
// Optional overflow flag: define CSA_ACCUMULATOR_OVF_EN to add out_ovf.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NUM_OPS   = 3,
  parameter int ACC_WIDTH = WIDTH + 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]   in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_sum,
  output logic [OUT_BEATS_W-1:0]     out_beats
`ifdef CSA_ACCUMULATOR_OVF_EN
  , output logic                     out_ovf
`endif
);

  localparam int NVEC   = NUM_OPS + 2;
  localparam int LEVELS = csa_levels(NVEC);

  csa_state_e                 state_q;
  logic [ACC_WIDTH-1:0]       acc_s_q, acc_c_q, acc_s_d, acc_c_d;
  logic [OUT_BEATS_W-1:0]     beat_q, beat_d;
  logic [ACC_WIDTH-1:0]       out_sum_q;
  logic [OUT_BEATS_W-1:0]     out_beats_q;
  logic                       out_valid_q;
  logic [ACC_WIDTH-1:0]       v0 [NVEC];

  assign v0[0] = acc_s_q;
  assign v0[1] = acc_c_q;
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    assign v0[2+k] = ACC_WIDTH'(in_data[k*WIDTH +: WIDTH]);
  end

  // Each level compresses full triples and passes leftovers straight through.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = csa_count(NVEC, l);
    localparam int G  = NI / 3;
    localparam int NO = 2 * G + (NI % 3);
    logic [ACC_WIDTH-1:0] vi [NI];
    logic [ACC_WIDTH-1:0] vo [NO];
    logic [G-1:0]         drop;

    for (genvar j = 0; j < NI; j++) begin : g_in
      if (l == 0) begin : g_first
        assign vi[j] = v0[j];
      end else begin : g_next
        assign vi[j] = g_lvl[l-1].vo[j];
      end
    end

    for (genvar i = 0; i < G; i++) begin : g_csa
      csa_3to2 #(.W(ACC_WIDTH)) u_csa (
        .a         (vi[3*i]),
        .b         (vi[3*i+1]),
        .c         (vi[3*i+2]),
        .sum       (vo[2*i]),
        .carry     (vo[2*i+1]),
        .carry_drop(drop[i])
      );
    end

    for (genvar j = 0; j < NI % 3; j++) begin : g_pass
      assign vo[2*G+j] = vi[3*G+j];
    end

`ifdef CSA_ACCUMULATOR_OVF_EN
    logic any;
    if (l == 0) begin : g_any0
      assign any = |drop;
    end else begin : g_anyn
      assign any = g_lvl[l-1].any | (|drop);
    end
`else
    logic unused_drop;
    assign unused_drop = |drop;
`endif
  end

  assign acc_s_d = g_lvl[LEVELS-1].vo[0];
  assign acc_c_d = g_lvl[LEVELS-1].vo[1];
  assign beat_d  = (beat_q == '1) ? beat_q : beat_q + 1'b1;

`ifdef CSA_ACCUMULATOR_OVF_EN
  logic [ACC_WIDTH:0] cpa;
  logic               ovf_q, out_ovf_q;
  assign cpa     = {1'b0, acc_s_q} + {1'b0, acc_c_q};
  assign out_ovf = out_ovf_q;
`else
  logic [ACC_WIDTH-1:0] cpa;
  assign cpa = acc_s_q + acc_c_q;
`endif

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      beat_q      <= '0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
`ifdef CSA_ACCUMULATOR_OVF_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: if (in_valid) begin
          acc_s_q <= acc_s_d;
          acc_c_q <= acc_c_d;
          beat_q  <= beat_d;
`ifdef CSA_ACCUMULATOR_OVF_EN
          ovf_q   <= ovf_q | g_lvl[LEVELS-1].any;
`endif
          if (in_last) state_q <= RESOLVE;
        end
        RESOLVE: begin
          out_sum_q   <= cpa[ACC_WIDTH-1:0];
          out_beats_q <= beat_q;
          out_valid_q <= 1'b1;
          acc_s_q     <= '0;
          acc_c_q     <= '0;
          beat_q      <= '0;
`ifdef CSA_ACCUMULATOR_OVF_EN
          out_ovf_q   <= ovf_q | cpa[ACC_WIDTH];
          ovf_q       <= 1'b0;
`endif
          state_q     <= OUTPUT;
        end
        OUTPUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule
